// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the EX-stage branch redirect controller:
// branch codes, FSM state encoding and the default flush length.
package branch_redirect_ctrl_pkg;

   localparam logic [2:0] BR_NONE = 3'd0;
   localparam logic [2:0] BR_BEQ  = 3'd1;
   localparam logic [2:0] BR_BNE  = 3'd2;
   localparam logic [2:0] BR_BLT  = 3'd3;
   localparam logic [2:0] BR_BGE  = 3'd4;
   localparam logic [2:0] BR_BLTU = 3'd5;
   localparam logic [2:0] BR_BGEU = 3'd6;
   localparam logic [2:0] BR_JUMP = 3'd7;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] REDIRECT = 2'd1;
   localparam logic [1:0] FLUSH    = 2'd2;

   localparam int FLUSH_CYCLES_DEFAULT = 2;
   localparam int FLUSH_CNT_W          = 4;

endpackage

// File: rtl/branch_redirect_ctrl_br_cond_eval.sv
// Pure combinational branch condition: maps the branch code and ALU compare
// flags to a taken decision. Shared with the branch predictor checker.
module br_cond_eval
   import branch_redirect_ctrl_pkg::*;
(
   input  logic [2:0] br_signal,
   input  logic       eq,
   input  logic       lt,
   input  logic       ltu,
   output logic       taken
);

   // NOTE: taken gets a default before the case so no latch is inferred.
   always_comb begin
      taken = 1'b0;
      case (br_signal)
         BR_BEQ:  taken = eq;
         BR_BNE:  taken = !eq;
         BR_BLT:  taken = lt;
         BR_BGE:  taken = !lt;
         BR_BLTU: taken = ltu;
         BR_BGEU: taken = !ltu;
         BR_JUMP: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch redirect and bounded pipeline flush sequencer.
// Optional statistics counters are enabled with `define BRANCH_STATS_EN.
module branch_redirect_ctrl
   import branch_redirect_ctrl_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
   parameter int CNT_W        = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             EX_VALID,
   input  logic [2:0]       BR_SIGNAL,
   input  logic             EQ,
   input  logic             LT,
   input  logic             LTU,
   input  logic [XLEN-1:0]  BR_TARGET,
   input  logic             STALL,
   output logic             PC_SEL,
   output logic [XLEN-1:0]  PC_TARGET,
   output logic             FLUSH_IFID,
   output logic             FLUSH_IDEX,
   output logic             BUSY,
   output logic [CNT_W-1:0] BR_TOTAL,
   output logic [CNT_W-1:0] BR_TAKEN
);

   logic [1:0]             state;
   logic [FLUSH_CNT_W-1:0] flush_cnt;
   logic                   taken;
   logic                   accept;

   br_cond_eval u_cond (
      .br_signal (BR_SIGNAL),
      .eq        (EQ),
      .lt        (LT),
      .ltu       (LTU),
      .taken     (taken)
   );

   // Wrong-path branches behind a redirect are dropped because only IDLE accepts.
   assign accept = (state == IDLE) && EX_VALID && (BR_SIGNAL != BR_NONE) && !STALL;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         flush_cnt <= '0;
         PC_TARGET <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept && taken) begin
                  PC_TARGET <= BR_TARGET;
                  state     <= REDIRECT;
               end
            end
            REDIRECT: begin
               if (!STALL) begin
                  if (FLUSH_CYCLES == 1) begin
                     state <= IDLE;
                  end else begin
                     flush_cnt <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
                     state     <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               if (!STALL) begin
                  flush_cnt <= flush_cnt - 1'b1;
                  if (flush_cnt == FLUSH_CNT_W'(1)) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign PC_SEL     = (state == REDIRECT);
   assign FLUSH_IFID = (state == REDIRECT) || (state == FLUSH);
   assign FLUSH_IDEX = FLUSH_IFID;
   assign BUSY       = FLUSH_IFID;

`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0] total_q;
   logic [CNT_W-1:0] taken_q;

   // Saturating counters, cleared only by reset.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         total_q <= '0;
         taken_q <= '0;
      end else if (accept) begin
         if (total_q != '1) total_q <= total_q + 1'b1;
         if (taken && (taken_q != '1)) taken_q <= taken_q + 1'b1;
      end
   end

   assign BR_TOTAL = total_q;
   assign BR_TAKEN = taken_q;
`else
   assign BR_TOTAL = '0;
   assign BR_TAKEN = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: table of single-branch vectors
// plus directed sequences for stall, wrong-path, async reset and statistics.
module tb_branch_redirect_ctrl;
   import branch_redirect_ctrl_pkg::*;

   localparam int XLEN  = 32;
   localparam int CNT_W = 2;

   logic             CLK = 1'b0;
   logic             RESET;
   logic             EX_VALID;
   logic [2:0]       BR_SIGNAL;
   logic             EQ, LT, LTU;
   logic [XLEN-1:0]  BR_TARGET;
   logic             STALL;
   logic             PC_SEL;
   logic [XLEN-1:0]  PC_TARGET;
   logic             FLUSH_IFID, FLUSH_IDEX, BUSY;
   logic [CNT_W-1:0] BR_TOTAL, BR_TAKEN;

   int n_cmp = 0;
   int n_err = 0;

   branch_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RESET(RESET), .EX_VALID(EX_VALID), .BR_SIGNAL(BR_SIGNAL),
      .EQ(EQ), .LT(LT), .LTU(LTU), .BR_TARGET(BR_TARGET), .STALL(STALL),
      .PC_SEL(PC_SEL), .PC_TARGET(PC_TARGET), .FLUSH_IFID(FLUSH_IFID),
      .FLUSH_IDEX(FLUSH_IDEX), .BUSY(BUSY), .BR_TOTAL(BR_TOTAL), .BR_TAKEN(BR_TAKEN)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        valid;
      logic [2:0]  code;
      logic        eq, lt, ltu;
      logic [31:0] target;
      logic        exp_taken;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic [2:0] code, input logic eq, input logic lt,
                        input logic ltu, input logic [31:0] tgt);
      EX_VALID  = 1'b1;
      BR_SIGNAL = code;
      EQ = eq; LT = lt; LTU = ltu;
      BR_TARGET = tgt;
   endtask

   task automatic clear_br();
      EX_VALID  = 1'b0;
      BR_SIGNAL = BR_NONE;
   endtask

   task automatic check_ctrl(input string name, input logic pc_sel, input logic flush,
                             input logic [31:0] pc);
      check({name, ".pc_sel"},  {31'd0, PC_SEL},     {31'd0, pc_sel});
      check({name, ".fl_ifid"}, {31'd0, FLUSH_IFID}, {31'd0, flush});
      check({name, ".fl_idex"}, {31'd0, FLUSH_IDEX}, {31'd0, flush});
      check({name, ".busy"},    {31'd0, BUSY},       {31'd0, flush});
      check({name, ".pc_tgt"},  PC_TARGET,           pc);
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
   endtask

   initial begin
      RESET = 1'b1; STALL = 1'b0; EQ = 0; LT = 0; LTU = 0; BR_TARGET = '0;
      clear_br();

      //            valid code     eq lt ltu target        taken exp_pc
      vecs[0]  = '{1'b1, BR_NONE, 1, 0, 0, 32'h0000_0010, 1'b0, 32'h0000_0000};
      vecs[1]  = '{1'b1, BR_BEQ,  1, 0, 0, 32'h0000_0100, 1'b1, 32'h0000_0100};
      vecs[2]  = '{1'b1, BR_BNE,  1, 0, 0, 32'h0000_0300, 1'b0, 32'h0000_0100};
      vecs[3]  = '{1'b1, BR_BNE,  0, 0, 0, 32'h0000_0104, 1'b1, 32'h0000_0104};
      vecs[4]  = '{1'b1, BR_BLT,  0, 1, 0, 32'h0000_0108, 1'b1, 32'h0000_0108};
      vecs[5]  = '{1'b1, BR_BLT,  0, 0, 1, 32'h0000_0500, 1'b0, 32'h0000_0108};
      vecs[6]  = '{1'b1, BR_BGE,  0, 0, 1, 32'h0000_010C, 1'b1, 32'h0000_010C};
      vecs[7]  = '{1'b1, BR_BGE,  0, 1, 0, 32'h0000_0600, 1'b0, 32'h0000_010C};
      vecs[8]  = '{1'b1, BR_BLTU, 0, 0, 1, 32'h0000_0110, 1'b1, 32'h0000_0110};
      vecs[9]  = '{1'b1, BR_BLTU, 0, 1, 0, 32'h0000_0700, 1'b0, 32'h0000_0110};
      vecs[10] = '{1'b1, BR_BGEU, 0, 1, 0, 32'h0000_0116, 1'b1, 32'h0000_0116};
      vecs[11] = '{1'b1, BR_BGEU, 0, 0, 1, 32'h0000_0800, 1'b0, 32'h0000_0116};
      vecs[12] = '{1'b0, BR_JUMP, 0, 0, 0, 32'h0000_0900, 1'b0, 32'h0000_0116};
      vecs[13] = '{1'b1, BR_JUMP, 0, 0, 0, 32'h0000_2003, 1'b1, 32'h0000_2003};

      // Reset state, checked while reset is still asserted
      #2;
      check_ctrl("reset", 1'b0, 1'b0, 32'h0);
      check("reset.total", {30'd0, BR_TOTAL}, 32'd0);
      check("reset.taken", {30'd0, BR_TAKEN}, 32'd0);
      do_reset();

      // Table of single branches from IDLE
      for (int i = 0; i < 14; i++) begin
         issue(vecs[i].code, vecs[i].eq, vecs[i].lt, vecs[i].ltu, vecs[i].target);
         EX_VALID = vecs[i].valid;
         tick();
         clear_br();
         check_ctrl($sformatf("vec%0d.c1", i), vecs[i].exp_taken, vecs[i].exp_taken, vecs[i].exp_pc);
         tick();
         check_ctrl($sformatf("vec%0d.c2", i), 1'b0, vecs[i].exp_taken, vecs[i].exp_pc);
         tick();
         check_ctrl($sformatf("vec%0d.c3", i), 1'b0, 1'b0, vecs[i].exp_pc);
      end

      // Stall held for 3 cycles in REDIRECT
      issue(BR_BEQ, 1, 0, 0, 32'h0000_0100);
      tick();
      clear_br();
      STALL = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_ctrl($sformatf("stall.hold%0d", k), 1'b1, 1'b1, 32'h100);
      end
      STALL = 1'b0;
      tick();
      check_ctrl("stall.flush", 1'b0, 1'b1, 32'h100);
      tick();
      check_ctrl("stall.idle", 1'b0, 1'b0, 32'h100);

      // Taken branch under stall waits until stall drops
      STALL = 1'b1;
      issue(BR_JUMP, 0, 0, 0, 32'h0000_0900);
      tick();
      check_ctrl("stallacc.blocked", 1'b0, 1'b0, 32'h100);
      STALL = 1'b0;
      tick();
      clear_br();
      check_ctrl("stallacc.redir", 1'b1, 1'b1, 32'h900);
      tick();
      tick();
      check_ctrl("stallacc.idle", 1'b0, 1'b0, 32'h900);

      // Wrong-path branch while busy is ignored
      issue(BR_BEQ, 1, 0, 0, 32'h0000_0100);
      tick();
      issue(BR_BGEU, 0, 0, 0, 32'h0000_0200);
      tick();
      check_ctrl("b2b.flush", 1'b0, 1'b1, 32'h100);
      tick();
      clear_br();
      check_ctrl("b2b.idle", 1'b0, 1'b0, 32'h100);
      tick();
      check_ctrl("b2b.noredir", 1'b0, 1'b0, 32'h100);

      // Asynchronous reset mid-FLUSH
      issue(BR_BEQ, 1, 0, 0, 32'h0000_0100);
      tick();
      clear_br();
      tick();
      check_ctrl("rst.preflush", 1'b0, 1'b1, 32'h100);
      RESET = 1'b1;
      #1;
      check_ctrl("rst.async", 1'b0, 1'b0, 32'h0);
      #1;
      RESET = 1'b0;
      issue(BR_JUMP, 0, 0, 0, 32'h0000_0044);
      tick();
      clear_br();
      check_ctrl("rst.jump", 1'b1, 1'b1, 32'h44);
      tick();
      tick();
      check_ctrl("rst.done", 1'b0, 1'b0, 32'h44);

      // Statistics: 5 accepted, 4 taken, 2-bit counters saturate at 3
      do_reset();
      for (int k = 0; k < 5; k++) begin
         case (k)
            0: issue(BR_BEQ,  1, 0, 0, 32'h10);
            1: issue(BR_BNE,  1, 0, 0, 32'h20);
            2: issue(BR_JUMP, 0, 0, 0, 32'h30);
            3: issue(BR_BLT,  0, 1, 0, 32'h40);
            default: issue(BR_BGEU, 0, 0, 0, 32'h50);
         endcase
         tick();
         clear_br();
         tick();
         tick();
      end
`ifdef BRANCH_STATS_EN
      check("stats.total", {30'd0, BR_TOTAL}, 32'd3);
      check("stats.taken", {30'd0, BR_TAKEN}, 32'd3);
`else
      check("stats.total", {30'd0, BR_TOTAL}, 32'd0);
      check("stats.taken", {30'd0, BR_TAKEN}, 32'd0);
`endif
      check("stats.pc", PC_TARGET, 32'h50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
